ctl_game: RTL and testbench

Game sequencer for Duck Hunt. Runs the round loop: it launches each duck, counts shots and frames while the duck is in flight, and decides hit, escape and game over. It drives the duck respawn, the score/ammo reset and the overlay "looser" flag. It sits in the ctrl section between the trigger logic (`ctl_trigger`) and `ctl_duck`, `ctl_score`, `ctl_ammo` and `draw_overlay`, all in the 65 MHz domain.

---
 rtl/ctl_game_if.sv | 25 ++
 rtl/ctl_game.sv | 119 +++++++++++
 tb/tb_ctl_game.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ctl_game_if.sv
// ctl_game_if: handshake/status bundle between the Duck Hunt game sequencer and the ctrl section.
//   master: drives new_frame, start_btn, pause, hit, miss; observes sequencer outputs
//   slave : the sequencer (ctl_game)
interface ctl_game_if;
    logic       new_frame;
    logic       start_btn;
    logic       pause;
    logic       hit;
    logic       miss;
    logic       duck_launch;
    logic       duck_active;
    logic       reset_score;
    logic       looser;
    logic       game_running;
    logic [3:0] round_num;
    logic [3:0] hit_cnt;
    modport master (
        output new_frame, start_btn, pause, hit, miss,
        input  duck_launch, duck_active, reset_score, looser, game_running, round_num, hit_cnt
    );
    modport slave (
        input  new_frame, start_btn, pause, hit, miss,
        output duck_launch, duck_active, reset_score, looser, game_running, round_num, hit_cnt
    );
endinterface

// File: rtl/ctl_game.sv
// ctl_game: Duck Hunt round sequencer (launch, flight, hit/escape result, game over).
//   clk, rst : 65 MHz clock, synchronous active-high reset
//   bus      : ctl_game_if.slave (frame tick, start/pause, hit/miss in; launch, active,
//              reset_score, looser, game_running, round_num, hit_cnt out)
//   CTL_GAME_SPEEDUP_EN: when defined, flight length shrinks by 16 frames per round (floor 60).
module ctl_game #(
    parameter int ROUNDS_PER_GAME = 10,
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int FLIGHT_FRAMES   = 300,
    parameter int RESULT_FRAMES   = 60,
    parameter int MIN_HITS        = 6
) (
    input logic       clk,
    input logic       rst,
    ctl_game_if.slave bus
);
    localparam int FW = $clog2(FLIGHT_FRAMES + 1);
    localparam int RW = $clog2(RESULT_FRAMES + 1);
    localparam int SW = $clog2(SHOTS_PER_DUCK + 1);
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_FLIGHT, S_RESULT, S_OVER} state_t;
    state_t r_state, w_next;
    logic          r_start_q, w_edge;
    logic [SW-1:0] r_shots;
    logic [FW-1:0] r_frames, w_limit;
    logic [RW-1:0] r_res;
    logic [3:0]    r_round, r_hits;
    logic          r_launch, r_active, r_rscore, r_looser, r_running;
    logic          w_launch, w_active, w_rscore, w_looser, w_running;
    logic          w_shot_out, w_time_out, w_res_done, w_wait_start;
    // Tracks the button even while paused so a held button never looks like a new press.
    always_ff @(posedge clk) r_start_q <= bus.start_btn;
    assign w_edge       = bus.start_btn & ~r_start_q;
    assign w_wait_start = (r_state == S_IDLE) || (r_state == S_OVER);
    assign w_shot_out   = bus.miss && int'(r_shots) + 1 >= SHOTS_PER_DUCK;
    assign w_time_out   = bus.new_frame && int'(r_frames) + 1 >= int'(w_limit);
    assign w_res_done   = bus.new_frame && int'(r_res) + 1 >= RESULT_FRAMES;
`ifdef CTL_GAME_SPEEDUP_EN
    logic [FW-1:0] r_limit;
    int            w_lim;
    // r_round already holds the new round number while in LAUNCH.
    always_comb w_lim = FLIGHT_FRAMES - 16 * (int'(r_round) - 1);
    always_ff @(posedge clk) begin
        if (rst)
            r_limit <= FW'(FLIGHT_FRAMES);
        else if (!bus.pause && r_state == S_LAUNCH)
            r_limit <= FW'(w_lim < 60 ? 60 : w_lim);
    end
    assign w_limit = r_limit;
`else
    assign w_limit = FW'(FLIGHT_FRAMES);
`endif
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else if (!bus.pause)
            r_state <= w_next;
    end
    // The start edge first raises reset_score; the registered pulse then moves the FSM to LAUNCH,
    // which places duck_launch exactly one cycle after reset_score.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_OVER: w_next = r_rscore ? S_LAUNCH : r_state;
            S_LAUNCH:       w_next = S_FLIGHT;
            S_FLIGHT:       w_next = (bus.hit || w_shot_out || w_time_out) ? S_RESULT : S_FLIGHT;
            S_RESULT:       w_next = !w_res_done ? S_RESULT :
                                     (int'(r_round) >= ROUNDS_PER_GAME ? S_OVER : S_LAUNCH);
            default:        w_next = S_IDLE;
        endcase
    end
    always_comb begin
        w_rscore  = w_wait_start && w_edge && !r_rscore;
        w_launch  = w_next == S_LAUNCH;
        w_active  = w_next == S_FLIGHT;
        w_running = !(w_next == S_IDLE || w_next == S_OVER);
        w_looser  = w_next == S_OVER && int'(r_hits) < MIN_HITS;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_launch  <= 1'b0;
            r_active  <= 1'b0;
            r_rscore  <= 1'b0;
            r_looser  <= 1'b0;
            r_running <= 1'b0;
            r_round   <= '0;
            r_hits    <= '0;
            r_shots   <= '0;
            r_frames  <= '0;
            r_res     <= '0;
        end else if (!bus.pause) begin
            r_launch  <= w_launch;
            r_active  <= w_active;
            r_rscore  <= w_rscore;
            r_looser  <= w_looser;
            r_running <= w_running;
            r_round   <= (w_wait_start && w_next == S_LAUNCH) ? 4'd1 :
                         (r_state == S_RESULT && w_next == S_LAUNCH && r_round != 4'hF) ? r_round + 4'd1 :
                         r_round;
            r_hits    <= (w_wait_start && w_next == S_LAUNCH) ? '0 :
                         (r_state == S_FLIGHT && bus.hit && r_hits != 4'hF) ? r_hits + 4'd1 : r_hits;
            // A hit in the same cycle as a miss leaves the shot counter alone.
            r_shots   <= r_state == S_LAUNCH ? '0 :
                         (r_state == S_FLIGHT && !bus.hit && bus.miss && int'(r_shots) < SHOTS_PER_DUCK) ?
                         r_shots + SW'(1) : r_shots;
            r_frames  <= r_state == S_LAUNCH ? '0 :
                         (r_state == S_FLIGHT && bus.new_frame && int'(r_frames) < FLIGHT_FRAMES) ?
                         r_frames + FW'(1) : r_frames;
            r_res     <= r_state != S_RESULT ? '0 :
                         (bus.new_frame && int'(r_res) < RESULT_FRAMES) ? r_res + RW'(1) : r_res;
        end
    end
    assign bus.duck_launch  = r_launch;
    assign bus.duck_active  = r_active;
    assign bus.reset_score  = r_rscore;
    assign bus.looser       = r_looser;
    assign bus.game_running = r_running;
    assign bus.round_num    = r_round;
    assign bus.hit_cnt      = r_hits;
endmodule

// File: tb/tb_ctl_game.sv
// tb_ctl_game: directed scoreboard bench for the ctl_game sequencer.
module tb_ctl_game;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ctl_game_if bus();
    ctl_game dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
`ifdef CTL_GAME_SPEEDUP_EN
    localparam int L3 = 268;
    localparam int L5 = 236;
`else
    localparam int L3 = 300;
    localparam int L5 = 300;
`endif
    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;
    task automatic put(input string t, input logic [31:0] v);
        sb.push_back('{t, v});
    endtask
    task automatic chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_empty obs=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s obs=%0d exp=%0d", e.tag, obs, e.v);
            end
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic frames(input int n);
        bus.new_frame = 1'b1;
        tick(n);
        bus.new_frame = 1'b0;
    endtask
    task automatic play_round(input bit h);
        tick(1);
        if (h) begin
            bus.hit = 1'b1;
            tick(1);
            bus.hit = 1'b0;
        end else begin
            bus.miss = 1'b1;
            tick(3);
            bus.miss = 1'b0;
        end
        frames(60);
    endtask
    initial begin
        bus.new_frame = 1'b0;
        bus.start_btn = 1'b0;
        bus.pause     = 1'b0;
        bus.hit       = 1'b0;
        bus.miss      = 1'b0;
        tick(3);
        rst = 1'b0;
        put("rst_reset_score", 0); put("rst_launch", 0); put("rst_active", 0);
        put("rst_looser", 0); put("rst_running", 0); put("rst_round", 0); put("rst_hits", 0);
        tick(1);
        chk(bus.reset_score); chk(bus.duck_launch); chk(bus.duck_active);
        chk(bus.looser); chk(bus.game_running); chk(bus.round_num); chk(bus.hit_cnt);
        // game 1: start edge
        put("start_reset_score", 1); put("start_no_launch", 0);
        bus.start_btn = 1'b1;
        tick(1);
        chk(bus.reset_score); chk(bus.duck_launch);
        put("launch_pulse", 1); put("reset_score_one_cycle", 0); put("launch_round", 1);
        tick(1);
        chk(bus.duck_launch); chk(bus.reset_score); chk(bus.round_num);
        put("flight_active", 1); put("launch_one_cycle", 0); put("flight_running", 1);
        tick(1);
        chk(bus.duck_active); chk(bus.duck_launch); chk(bus.game_running);
        bus.start_btn = 1'b0;
        // round 1: hit
        put("r1_hit_cnt", 1); put("r1_inactive", 0);
        bus.hit = 1'b1;
        tick(1);
        bus.hit = 1'b0;
        chk(bus.hit_cnt); chk(bus.duck_active);
        put("r1_hit_in_result_ignored", 1);
        bus.hit = 1'b1;
        tick(1);
        bus.hit = 1'b0;
        chk(bus.hit_cnt);
        put("r1_result_59", 0);
        frames(59);
        chk(bus.duck_launch);
        put("r1_result_60_launch", 1); put("r2_round", 2);
        frames(1);
        chk(bus.duck_launch); chk(bus.round_num);
        // round 2: three misses
        tick(1);
        put("r2_two_misses_active", 1);
        bus.miss = 1'b1;
        tick(2);
        chk(bus.duck_active);
        put("r2_third_miss_escape", 0); put("r2_hits_unchanged", 1);
        tick(1);
        bus.miss = 1'b0;
        chk(bus.duck_active); chk(bus.hit_cnt);
        put("r3_round", 3);
        frames(60);
        chk(bus.round_num);
        // round 3: flight timeout
        tick(1);
        put("r3_before_timeout", 1);
        frames(L3 - 1);
        chk(bus.duck_active);
        put("r3_timeout", 0);
        frames(1);
        chk(bus.duck_active);
        put("r4_round", 4);
        frames(60);
        chk(bus.round_num);
        // round 4: hit and miss together count as a hit
        tick(1);
        put("r4_hit_miss_hits", 2); put("r4_hit_miss_inactive", 0);
        bus.hit = 1'b1;
        bus.miss = 1'b1;
        tick(1);
        bus.hit = 1'b0;
        bus.miss = 1'b0;
        chk(bus.hit_cnt); chk(bus.duck_active);
        put("r5_round", 5);
        frames(60);
        chk(bus.round_num);
        // round 5: pause mid-flight
        tick(1);
        frames(10);
        put("pause_active", 1); put("pause_hits", 2); put("pause_round", 5); put("pause_running", 1);
        bus.pause = 1'b1;
        bus.hit = 1'b1;
        frames(500);
        bus.hit = 1'b0;
        chk(bus.duck_active); chk(bus.hit_cnt); chk(bus.round_num); chk(bus.game_running);
        bus.pause = 1'b0;
        put("r5_after_pause_active", 1);
        frames(L5 - 11);
        chk(bus.duck_active);
        put("r5_after_pause_timeout", 0);
        frames(1);
        chk(bus.duck_active);
        put("r6_round", 6);
        frames(60);
        chk(bus.round_num);
        // rounds 6..10: three hits then two escapes, 5 hits total
        for (int r = 6; r <= 10; r++) begin
            play_round(r <= 8);
            if (r < 10) begin
                put("g1_round", r + 1);
                chk(bus.round_num);
            end
        end
        put("g1_looser", 1); put("g1_running", 0); put("g1_hits", 5); put("g1_round_final", 10);
        put("g1_over_active", 0);
        chk(bus.looser); chk(bus.game_running); chk(bus.hit_cnt); chk(bus.round_num); chk(bus.duck_active);
        put("g1_looser_held", 1);
        tick(5);
        chk(bus.looser);
        // restart from GAME_OVER
        put("g2_reset_score", 1);
        bus.start_btn = 1'b1;
        tick(1);
        chk(bus.reset_score);
        put("g2_launch", 1); put("g2_hits_cleared", 0); put("g2_round", 1); put("g2_looser_clear", 0);
        tick(1);
        bus.start_btn = 1'b0;
        chk(bus.duck_launch); chk(bus.hit_cnt); chk(bus.round_num); chk(bus.looser);
        // game 2: six hits then four escapes
        for (int r = 1; r <= 10; r++) begin
            play_round(r <= 6);
            if (r < 10) begin
                put("g2_round", r + 1);
                chk(bus.round_num);
            end
        end
        put("g2_looser", 0); put("g2_running", 0); put("g2_hits", 6);
        chk(bus.looser); chk(bus.game_running); chk(bus.hit_cnt);
        // reset from GAME_OVER
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        put("rst2_round", 0); put("rst2_hits", 0); put("rst2_reset_score", 0);
        tick(1);
        chk(bus.round_num); chk(bus.hit_cnt); chk(bus.reset_score);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
